// File: rtl/module_display_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : module_display_mux
//  Purpose  : Time-multiplexed 7-segment display driver. Each scan tick steps
//             to the next digit; every digit is preceded by an all-anodes-off
//             blank interval to stop ghosting. Display data is copied into
//             shadow registers once per frame, so a frame never tears.
//  Ports    : clk_10Mhz_i   system clock
//             reset_i       synchronous, active-high reset
//             scan_tick_i   one-cycle advance pulse from the scan divider
//             enable_i      1 = display active, 0 = all digits off
//             data_i        hex value, nibble k shown on digit k
//             dp_i          decimal point per digit, 1 = lit
//             lz_blank_i    1 = suppress leading zeros
//             anodo_o       digit enables, active-low, one-hot-low
//             catodo_o      segments {g,f,e,d,c,b,a}, active-low
//             dp_o          decimal-point segment, active-low
//             frame_done_o  one-cycle pulse when a frame's data is latched
//  Revision : 1.0 - initial release
// ============================================================================
module module_display_mux #(
    parameter int N_DIGITS     = 4,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk_10Mhz_i,
    input  logic                  reset_i,
    input  logic                  scan_tick_i,
    input  logic                  enable_i,
    input  logic [4*N_DIGITS-1:0] data_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic                  lz_blank_i,
    output logic [N_DIGITS-1:0]   anodo_o,
    output logic [6:0]            catodo_o,
    output logic                  dp_o,
    output logic                  frame_done_o
);

    localparam int c_IDX_W        = $clog2(N_DIGITS);
    localparam int c_CNT_W        = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    // With BLANK_CYCLES = 0 the terminal count is 0, giving a one-cycle blank.
    localparam int c_BLANK_LAST_I = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [c_CNT_W-1:0]  c_BLANK_LAST = c_BLANK_LAST_I[c_CNT_W-1:0];
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST   = c_IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] c_ONE        = N_DIGITS'(1);
    localparam logic [N_DIGITS-1:0] c_ANODES_OFF = '1;
    localparam logic [6:0]          c_SEGS_OFF   = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [4*N_DIGITS-1:0] r_shadow_data;
    logic [N_DIGITS-1:0]   r_shadow_dp;
    logic [N_DIGITS-1:0]   r_anodo;
    logic [6:0]            r_catodo;
    logic                  r_dp;
    logic                  r_frame_done;

    logic [3:0]            w_nibble;
    logic [N_DIGITS-1:0]   w_digit_blank;
    logic [6:0]            w_seg_show;
    logic [N_DIGITS-1:0]   w_anode_show;
    logic                  w_last_digit;
    logic [c_IDX_W-1:0]    w_idx_next;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] f_hex7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Leading-zero mask: walk from the most significant digit down while the
    // nibbles stay zero. Digit 0 is never masked so a zero value reads "0".
    always_comb begin
        logic w_zero_run;
        w_zero_run    = 1'b1;
        w_digit_blank = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            w_zero_run       = w_zero_run && (r_shadow_data[4*k +: 4] == 4'h0);
            w_digit_blank[k] = w_zero_run && lz_blank_i && (k != 0);
        end
    end

    assign w_nibble     = r_shadow_data[{r_idx, 2'b00} +: 4];
    assign w_seg_show   = w_digit_blank[r_idx] ? c_SEGS_OFF : f_hex7(w_nibble);
    assign w_anode_show = ~(c_ONE << r_idx);
    assign w_last_digit = (r_idx == c_IDX_LAST);
    assign w_idx_next   = w_last_digit ? '0 : r_idx + 1'b1;

    // Outputs are loaded on the same edge that moves the state, so they always
    // describe the state the machine has just entered.
    always_ff @(posedge clk_10Mhz_i) begin
        if (reset_i) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_anodo       <= c_ANODES_OFF;
            r_catodo      <= c_SEGS_OFF;
            r_dp          <= 1'b1;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (!enable_i) begin
                // Shadow registers intentionally keep their contents.
                r_state  <= S_IDLE;
                r_idx    <= '0;
                r_cnt    <= '0;
                r_anodo  <= c_ANODES_OFF;
                r_catodo <= c_SEGS_OFF;
                r_dp     <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state       <= S_BLANK;
                        r_idx         <= '0;
                        r_cnt         <= '0;
                        r_shadow_data <= data_i;
                        r_shadow_dp   <= dp_i;
                        r_frame_done  <= 1'b1;
                        r_anodo       <= c_ANODES_OFF;
                        r_catodo      <= c_SEGS_OFF;
                        r_dp          <= 1'b1;
                    end
                    S_BLANK: begin
                        // Ticks arriving here are dropped, not queued.
                        if (r_cnt == c_BLANK_LAST) begin
                            r_state  <= S_SHOW;
                            r_cnt    <= '0;
                            r_anodo  <= w_anode_show;
                            r_catodo <= w_seg_show;
                            r_dp     <= ~r_shadow_dp[r_idx];
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_SHOW: begin
                        // Leaving SHOW on the tick means a held tick can only
                        // advance once; BLANK ignores the remainder.
                        if (scan_tick_i) begin
                            r_state  <= S_BLANK;
                            r_cnt    <= '0;
                            r_idx    <= w_idx_next;
                            r_anodo  <= c_ANODES_OFF;
                            r_catodo <= c_SEGS_OFF;
                            r_dp     <= 1'b1;
                            if (w_last_digit) begin
                                r_shadow_data <= data_i;
                                r_shadow_dp   <= dp_i;
                                r_frame_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        r_anodo  <= c_ANODES_OFF;
                        r_catodo <= c_SEGS_OFF;
                        r_dp     <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign anodo_o      = r_anodo;
    assign catodo_o     = r_catodo;
    assign dp_o         = r_dp;
    assign frame_done_o = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_module_display_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_module_display_mux
//  Purpose  : Self-checking bench for module_display_mux. A per-cycle monitor
//             pops expected digit records from a scoreboard queue whenever a
//             digit is switched on, and checks blank length and blank outputs.
//             A second instance runs with BLANK_CYCLES = 0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_module_display_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_tick;
    logic        enable;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz_blank;

    logic [3:0]  anodo,  anodo0;
    logic [6:0]  catodo, catodo0;
    logic        dp_out, dp_out0;
    logic        frame_done, frame_done0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard entries: {anode[3:0], segments[6:0], dp_o}
    logic [11:0] sb[$];
    logic [11:0] sb0[$];

    bit          mon_active = 1'b0;
    bit          mon_seen;
    int          mon_blank_run;
    logic [3:0]  mon_prev;
    int          mon_fd = 0;

    always #50 clk = ~clk;

    module_display_mux #(.N_DIGITS(4), .BLANK_CYCLES(16)) u_dut (
        .clk_10Mhz_i (clk),
        .reset_i     (reset),
        .scan_tick_i (scan_tick),
        .enable_i    (enable),
        .data_i      (data),
        .dp_i        (dp),
        .lz_blank_i  (lz_blank),
        .anodo_o     (anodo),
        .catodo_o    (catodo),
        .dp_o        (dp_out),
        .frame_done_o(frame_done)
    );

    module_display_mux #(.N_DIGITS(4), .BLANK_CYCLES(0)) u_dut0 (
        .clk_10Mhz_i (clk),
        .reset_i     (reset),
        .scan_tick_i (scan_tick),
        .enable_i    (enable),
        .data_i      (data),
        .dp_i        (dp),
        .lz_blank_i  (lz_blank),
        .anodo_o     (anodo0),
        .catodo_o    (catodo0),
        .dp_o        (dp_out0),
        .frame_done_o(frame_done0)
    );

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [11:0] exp_digit(input int k, input logic [15:0] d,
                                              input logic [3:0] dpv, input bit lz);
        logic [3:0] an;
        logic [6:0] seg;
        bit         blank;
        blank = lz && (k > 0);
        for (int j = k; j < 4; j++)
            if (d[4*j +: 4] != 4'h0) blank = 1'b0;
        seg   = blank ? 7'h7F : hex7(d[4*k +: 4]);
        an    = 4'hF;
        an[k] = 1'b0;
        return {an, seg, ~dpv[k]};
    endfunction

    function automatic void push_frame(input logic [15:0] d, input logic [3:0] dpv,
                                       input bit lz);
        for (int k = 0; k < 4; k++) sb.push_back(exp_digit(k, d, dpv, lz));
    endfunction

    // Advance n clocks; outputs are observed on the falling edge and inputs
    // change 1 ns after the rising edge.
    task automatic step(input int n);
        logic [11:0] exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!mon_active) begin
                mon_seen      = 1'b0;
                mon_blank_run = 0;
                mon_prev      = 4'hF;
            end else begin
                if (anodo == 4'hF) begin
                    mon_blank_run++;
                    n_cmp++;
                    if (catodo !== 7'h7F || dp_out !== 1'b1) begin
                        n_fail++;
                        $display("FAIL blank_outputs: got seg=%b dp=%b expected seg=1111111 dp=1",
                                 catodo, dp_out);
                    end
                end else begin
                    n_cmp++;
                    if ($countones(~anodo) != 1) begin
                        n_fail++;
                        $display("FAIL anode_onehot: got %b expected exactly one low bit", anodo);
                    end
                    if (mon_prev == 4'hF) begin
                        if (mon_seen) begin
                            n_cmp++;
                            if (mon_blank_run != 16) begin
                                n_fail++;
                                $display("FAIL blank_length: got %0d cycles expected 16",
                                         mon_blank_run);
                            end
                        end
                        n_cmp++;
                        if (sb.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_digit: got %b/%b/%b expected no new digit",
                                     anodo, catodo, dp_out);
                        end else begin
                            exp = sb.pop_front();
                            if ({anodo, catodo, dp_out} !== exp) begin
                                n_fail++;
                                $display("FAIL digit: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                                         anodo, catodo, dp_out, exp[11:8], exp[7:1], exp[0]);
                            end
                        end
                        mon_seen = 1'b1;
                    end
                    mon_blank_run = 0;
                end
                if (frame_done === 1'b1) mon_fd++;
                mon_prev = anodo;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        scan_tick = 1'b1;
        step(1);
        scan_tick = 1'b0;
    endtask

    task automatic wait_first_show(output int lat, output int fds);
        lat = -1;
        fds = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (frame_done === 1'b1) fds++;
            if (lat < 0 && anodo !== 4'hF) lat = i;
        end
    endtask

    task automatic do_reset();
        mon_active = 1'b0;
        reset      = 1'b1;
        enable     = 1'b0;
        scan_tick  = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);
        sb.delete();
        mon_active = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; scan_tick = 1'b0;
        data = 16'h0; dp = 4'h0; lz_blank = 1'b0;
        step(2);
        n_cmp++; if (anodo !== 4'hF) begin n_fail++; $display("FAIL reset_anodo: got %b expected 1111", anodo); end
        n_cmp++; if (catodo !== 7'h7F) begin n_fail++; $display("FAIL reset_catodo: got %b expected 1111111", catodo); end
        n_cmp++; if (dp_out !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", dp_out); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_cmp++; if (anodo0 !== 4'hF) begin n_fail++; $display("FAIL reset_anodo_b0: got %b expected 1111", anodo0); end
        reset = 1'b0;
        step(5);
        n_cmp++; if (anodo !== 4'hF || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL idle_disabled: got an=%b fd=%b expected an=1111 fd=0", anodo, frame_done);
        end
    endtask

    task automatic test_scan_and_latch();
        int lat, fds, fd0;
        do_reset();
        data = 16'h12AF; dp = 4'h0; lz_blank = 1'b0;
        push_frame(16'h12AF, 4'h0, 1'b0);
        push_frame(16'h0000, 4'h0, 1'b0);
        enable = 1'b1;
        wait_first_show(lat, fds);
        n_cmp++; if (lat != 17) begin n_fail++; $display("FAIL first_show_latency: got %0d expected 17", lat); end
        n_cmp++; if (fds != 1) begin n_fail++; $display("FAIL enable_frame_done: got %0d pulses expected 1", fds); end
        fd0 = mon_fd;
        pulse_tick(); step(40);
        pulse_tick(); step(25);
        n_cmp++; if (anodo !== 4'b1011) begin n_fail++; $display("FAIL digit2_showing: got %b expected 1011", anodo); end
        data = 16'h0000;
        step(15);
        pulse_tick(); step(40);
        n_cmp++; if (mon_fd != fd0) begin n_fail++; $display("FAIL midframe_no_latch: got %0d pulses expected 0", mon_fd - fd0); end
        pulse_tick(); step(40);
        n_cmp++; if (mon_fd != fd0 + 1) begin n_fail++; $display("FAIL wrap_frame_done: got %0d pulses expected 1", mon_fd - fd0); end
        repeat (3) begin pulse_tick(); step(40); end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain_scan: got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_lz_blank();
        int lat, fds;
        do_reset();
        data = 16'h0040; dp = 4'h0; lz_blank = 1'b1;
        push_frame(16'h0040, 4'h0, 1'b1);
        push_frame(16'h0000, 4'h0, 1'b1);
        enable = 1'b1;
        wait_first_show(lat, fds);
        n_cmp++; if (lat != 17) begin n_fail++; $display("FAIL lz_latency: got %0d expected 17", lat); end
        data = 16'h0000;
        repeat (7) begin pulse_tick(); step(40); end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain_lz: got %0d left expected 0", sb.size()); end
        lz_blank = 1'b0;
    endtask

    task automatic test_tick_hold();
        int lat, fds;
        do_reset();
        data = 16'h3C5E; dp = 4'b1010; lz_blank = 1'b0;
        sb.push_back(exp_digit(0, 16'h3C5E, 4'b1010, 1'b0));
        enable = 1'b1;
        wait_first_show(lat, fds);
        sb.push_back(exp_digit(1, 16'h3C5E, 4'b1010, 1'b0));
        scan_tick = 1'b1;
        step(5);
        scan_tick = 1'b0;
        step(3);
        pulse_tick();
        step(40);
        n_cmp++; if (anodo !== 4'b1101) begin n_fail++; $display("FAIL tick_in_blank_dropped: got %b expected 1101", anodo); end
        sb.push_back(exp_digit(2, 16'h3C5E, 4'b1010, 1'b0));
        pulse_tick(); step(40);
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain_hold: got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_enable_drop();
        int lat, fds;
        do_reset();
        data = 16'h12AF; dp = 4'h0; lz_blank = 1'b0;
        for (int k = 0; k < 3; k++) sb.push_back(exp_digit(k, 16'h12AF, 4'h0, 1'b0));
        enable = 1'b1;
        wait_first_show(lat, fds);
        pulse_tick(); step(40);
        pulse_tick(); step(40);
        n_cmp++; if (anodo !== 4'b1011) begin n_fail++; $display("FAIL drop_precondition: got %b expected 1011", anodo); end
        mon_active = 1'b0;
        enable = 1'b0;
        step(1);
        n_cmp++; if (anodo !== 4'hF) begin n_fail++; $display("FAIL drop_anodo: got %b expected 1111", anodo); end
        n_cmp++; if (catodo !== 7'h7F) begin n_fail++; $display("FAIL drop_catodo: got %b expected 1111111", catodo); end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain_drop: got %0d left expected 0", sb.size()); end
        data = 16'h5678;
        mon_active = 1'b1;
        sb.push_back(exp_digit(0, 16'h5678, 4'h0, 1'b0));
        enable = 1'b1;
        wait_first_show(lat, fds);
        n_cmp++; if (lat != 17) begin n_fail++; $display("FAIL reenable_latency: got %0d expected 17", lat); end
        n_cmp++; if (fds != 1) begin n_fail++; $display("FAIL reenable_frame_done: got %0d pulses expected 1", fds); end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain_reenable: got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_reset_midblank();
        int lat, fds;
        do_reset();
        data = 16'h1234; dp = 4'b0100; lz_blank = 1'b0;
        sb.push_back(exp_digit(0, 16'h1234, 4'b0100, 1'b0));
        enable = 1'b1;
        wait_first_show(lat, fds);
        pulse_tick(); step(4);
        n_cmp++; if (anodo !== 4'hF) begin n_fail++; $display("FAIL midblank_precondition: got %b expected 1111", anodo); end
        mon_active = 1'b0;
        reset = 1'b1;
        step(1);
        n_cmp++; if ({anodo, catodo, dp_out, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL midblank_reset: got an=%b seg=%b dp=%b fd=%b expected an=1111 seg=1111111 dp=1 fd=0",
                     anodo, catodo, dp_out, frame_done);
        end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain_midblank: got %0d left expected 0", sb.size()); end
        mon_active = 1'b1;
        sb.push_back(exp_digit(0, 16'h1234, 4'b0100, 1'b0));
        reset = 1'b0;
        wait_first_show(lat, fds);
        n_cmp++; if (lat != 17) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 17", lat); end
        n_cmp++; if (fds != 1) begin n_fail++; $display("FAIL post_reset_frame_done: got %0d pulses expected 1", fds); end
    endtask

    task automatic test_blank_zero();
        logic [3:0]  prev;
        logic [11:0] exp;
        int          run;
        bit          seen;
        do_reset();
        mon_active = 1'b0;
        data = 16'h1234; dp = 4'b0100; lz_blank = 1'b0;
        for (int k = 0; k < 4; k++) sb0.push_back(exp_digit(k, 16'h1234, 4'b0100, 1'b0));
        sb0.push_back(exp_digit(0, 16'h1234, 4'b0100, 1'b0));
        prev = 4'hF; run = 0; seen = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            step(1);
            n_cmp++;
            if (dp_out0 !== ((anodo0 == 4'b1011) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL b0_dp: got dp=%b with an=%b expected low only on digit 2", dp_out0, anodo0);
            end
            if (anodo0 == 4'hF) begin
                run++;
            end else begin
                if (prev == 4'hF) begin
                    if (seen) begin
                        n_cmp++;
                        if (run != 1) begin n_fail++; $display("FAIL b0_blank_length: got %0d expected 1", run); end
                    end
                    n_cmp++;
                    if (sb0.size() == 0) begin
                        n_fail++; $display("FAIL b0_unexpected_digit: got an=%b expected no new digit", anodo0);
                    end else begin
                        exp = sb0.pop_front();
                        if ({anodo0, catodo0, dp_out0} !== exp) begin
                            n_fail++;
                            $display("FAIL b0_digit: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                                     anodo0, catodo0, dp_out0, exp[11:8], exp[7:1], exp[0]);
                        end
                    end
                    seen = 1'b1;
                end
                run = 0;
            end
            prev = anodo0;
            scan_tick = (i % 10 == 5);
        end
        scan_tick = 1'b0;
        n_cmp++; if (sb0.size() != 0) begin n_fail++; $display("FAIL b0_sb_drain: got %0d left expected 0", sb0.size()); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected run to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_scan_and_latch();
        test_lz_blank();
        test_tick_hold();
        test_enable_drop();
        test_reset_midblank();
        test_blank_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
